// File: rtl/axi_rr_arbiter.sv
// AXI4-Lite N:1 arbiter. Read and write channels are arbitrated independently,
// each with its own round-robin pointer and at most one transaction in flight.
//
// state  | meaning
// R_IDLE | no read grant, waiting for any m_arvalid
// R_ADDR | granted master's AR forwarded to slave
// R_DATA | waiting for R handshake, routed to granted master
// W_IDLE | no write grant, waiting for any m_awvalid
// W_ADDR | granted master's AW and W forwarded until both handshake
// W_RESP | waiting for B handshake, routed to granted master
module axi_rr_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_M*ADDR_W-1:0]        m_araddr,
  input  logic [NUM_M-1:0]               m_arvalid,
  output logic [NUM_M-1:0]               m_arready,
  output logic [DATA_W-1:0]              m_rdata,
  output logic [1:0]                     m_rresp,
  output logic [NUM_M-1:0]               m_rvalid,
  input  logic [NUM_M-1:0]               m_rready,
  input  logic [NUM_M*ADDR_W-1:0]        m_awaddr,
  input  logic [NUM_M-1:0]               m_awvalid,
  output logic [NUM_M-1:0]               m_awready,
  input  logic [NUM_M*DATA_W-1:0]        m_wdata,
  input  logic [NUM_M*(DATA_W/8)-1:0]    m_wstrb,
  input  logic [NUM_M-1:0]               m_wvalid,
  output logic [NUM_M-1:0]               m_wready,
  output logic [1:0]                     m_bresp,
  output logic [NUM_M-1:0]               m_bvalid,
  input  logic [NUM_M-1:0]               m_bready,
  output logic [ADDR_W-1:0]              s_araddr,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic [1:0]                     s_rresp,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  output logic [ADDR_W-1:0]              s_awaddr,
  output logic                           s_awvalid,
  input  logic                           s_awready,
  output logic [DATA_W-1:0]              s_wdata,
  output logic [DATA_W/8-1:0]            s_wstrb,
  output logic                           s_wvalid,
  input  logic                           s_wready,
  input  logic [1:0]                     s_bresp,
  input  logic                           s_bvalid,
  output logic                           s_bready,
  output logic                           rd_busy,
  output logic                           wr_busy
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = DATA_W / 8;

  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2;

  logic [1:0]    r_state, w_state;
  logic [IW-1:0] r_grant, r_ptr, w_grant, w_ptr;
  logic          aw_done, w_done, aw_hs, w_hs;

  // First requester above ptr wins; otherwise wrap to the lowest requester.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] ptr,
                                            input logic [NUM_M-1:0] req);
    logic [IW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_M; i++)
      if (!found && req[i] && (IW'(i) > ptr)) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NUM_M; i++)
      if (!found && req[i]) begin
        pick  = IW'(i);
        found = 1'b1;
      end
    return pick;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_grant <= '0;
      r_ptr   <= IW'(NUM_M - 1);
    end else begin
      case (r_state)
        R_IDLE: if (|m_arvalid) begin
          r_grant <= rr_pick(r_ptr, m_arvalid);
          r_state <= R_ADDR;
        end
        R_ADDR: if (s_arvalid && s_arready) r_state <= R_DATA;
        R_DATA: if (s_rvalid && s_rready) begin
          r_ptr   <= r_grant;
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    for (int i = 0; i < NUM_M; i++)
      if (IW'(i) == r_grant) begin
        s_araddr     = m_araddr[i*ADDR_W +: ADDR_W];
        s_arvalid    = (r_state == R_ADDR) && m_arvalid[i];
        s_rready     = (r_state == R_DATA) && m_rready[i];
        m_arready[i] = (r_state == R_ADDR) && s_arready;
        m_rvalid[i]  = (r_state == R_DATA) && s_rvalid;
      end
  end

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_grant <= '0;
      w_ptr   <= IW'(NUM_M - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (|m_awvalid) begin
          w_grant <= rr_pick(w_ptr, m_awvalid);
          w_state <= W_ADDR;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        W_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          w_state <= W_RESP;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        W_RESP: if (s_bvalid && s_bready) begin
          w_ptr   <= w_grant;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Each forwarded valid is masked once its own handshake has been recorded.
  always_comb begin
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    for (int i = 0; i < NUM_M; i++)
      if (IW'(i) == w_grant) begin
        s_awaddr     = m_awaddr[i*ADDR_W +: ADDR_W];
        s_wdata      = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb      = m_wstrb[i*SW +: SW];
        s_awvalid    = (w_state == W_ADDR) && !aw_done && m_awvalid[i];
        s_wvalid     = (w_state == W_ADDR) && !w_done && m_wvalid[i];
        s_bready     = (w_state == W_RESP) && m_bready[i];
        m_awready[i] = (w_state == W_ADDR) && !aw_done && s_awready;
        m_wready[i]  = (w_state == W_ADDR) && !w_done && s_wready;
        m_bvalid[i]  = (w_state == W_RESP) && s_bvalid;
      end
  end

  assign m_bresp = s_bresp;
  assign rd_busy = (r_state != R_IDLE);
  assign wr_busy = (w_state != W_IDLE);

endmodule
